// File: rtl/fpga_tx_pkg.sv
// Shared definitions for the TX packet framer: FSM state encoding,
// fixed frame delimiters, frame type codes and the CRC-8 step used when
// the framer is built with TX_FRAMER_CRC8_EN.
package fpga_tx_pkg;

    // Framer state; the encoding is also exported on the framer's debug port.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SYNC     = 3'd2,
        TYPE     = 3'd3,
        LEN      = 3'd4,
        PAYLOAD  = 3'd5,
        CHECK    = 3'd6
    } tx_state_e;

    // Fixed frame delimiters.
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SYNC_BYTE     = 8'hD5;

    // Frame type codes written by the driver.
    localparam logic [7:0] TYPE_D_D = 8'h01;
    localparam logic [7:0] TYPE_N_A = 8'h02;
    localparam logic [7:0] TYPE_N_T = 8'h03;
    localparam logic [7:0] TYPE_N_Q = 8'h04;

    // One byte of CRC-8: poly 0x07, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO. dout always shows the
// head entry while the FIFO is not empty. A push is taken when there is
// room, or when the FIFO is full but a pop happens in the same cycle.
// A pop on an empty FIFO is ignored.
module tx_byte_fifo #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Depth is a power of two, so the count MSB alone marks "full".
    assign full  = count_q[AW];
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next pointer/count values from the accepted push and pop.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/tx_packet_framer.sv
// TX packet framer: buffers driver bytes in a FWFT FIFO and, on start_tx,
// streams preamble | sync | type | len | payload | check over valid/ready.
// Build option: TX_FRAMER_CRC8_EN selects a CRC-8 check byte; without it
// the check byte is the modulo-256 sum of type, len and payload.
//
// Output handshake: out_valid/out_data are driven from the current state;
// a byte is transferred on a rising edge where out_valid && out_ready, and
// while out_valid is high and out_ready is low, out_data holds steady.
module tx_packet_framer
    import fpga_tx_pkg::*;
#(
    parameter int FIFO_AW      = 7,
    parameter int PREAMBLE_LEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_tx,
    input  logic       wren_fifo_tx,
    output logic [7:0] size_fifo_tx,
    input  logic       start_tx,
    input  logic [7:0] frame_type,
    output logic       ready_tx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic [2:0] dbg_state
);

    tx_state_e      state_q, state_d;
    logic [3:0]     pre_cnt_q, pre_cnt_d;
    logic [7:0]     pay_cnt_q, pay_cnt_d;
    logic [7:0]     type_q, type_d;
    logic [7:0]     len_q, len_d;
    logic [7:0]     chk_q, chk_d;
    logic           overflow_q, overflow_d;

    logic           fifo_pop;
    logic [7:0]     fifo_head;
    logic [FIFO_AW:0] fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           hs;

    // Accumulate one byte into the running check value.
    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
`ifdef TX_FRAMER_CRC8_EN
        return crc8_step(acc, b);
`else
        return acc + b;
`endif
    endfunction

    tx_byte_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wren_fifo_tx),
        .din   (data_tx),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign size_fifo_tx = 8'(fifo_count);
    assign overflow     = overflow_q;
    assign dbg_state    = state_q;
    assign hs           = out_valid && out_ready;

    // Next-state, frame byte selection and check accumulation.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        pay_cnt_d  = pay_cnt_q;
        type_d     = type_q;
        len_d      = len_q;
        chk_d      = chk_q;
        fifo_pop   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        ready_tx   = 1'b0;
        // A write the FIFO could not take is remembered until reset.
        overflow_d = overflow_q | (wren_fifo_tx && fifo_full && !fifo_pop);

        case (state_q)
            IDLE: begin
                ready_tx = 1'b1;
                // Length is the fill level at start; later pushes wait for the next frame.
                if (start_tx && !fifo_empty) begin
                    state_d   = PREAMBLE;
                    pre_cnt_d = 4'(PREAMBLE_LEN - 1);
                    type_d    = frame_type;
                    len_d     = 8'(fifo_count);
                    chk_d     = 8'h00;
                end
            end
            PREAMBLE: begin
                out_valid = 1'b1;
                out_data  = PREAMBLE_BYTE;
                if (hs) begin
                    if (pre_cnt_q == 4'd0) begin
                        state_d = SYNC;
                    end else begin
                        pre_cnt_d = pre_cnt_q - 4'd1;
                    end
                end
            end
            SYNC: begin
                out_valid = 1'b1;
                out_data  = SYNC_BYTE;
                if (hs) begin
                    state_d = TYPE;
                end
            end
            TYPE: begin
                out_valid = 1'b1;
                out_data  = type_q;
                if (hs) begin
                    chk_d   = chk_next(chk_q, type_q);
                    state_d = LEN;
                end
            end
            LEN: begin
                out_valid = 1'b1;
                out_data  = len_q;
                if (hs) begin
                    chk_d     = chk_next(chk_q, len_q);
                    pay_cnt_d = len_q;
                    state_d   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = fifo_head;
                if (hs) begin
                    fifo_pop  = 1'b1;
                    chk_d     = chk_next(chk_q, fifo_head);
                    pay_cnt_d = pay_cnt_q - 8'd1;
                    if (pay_cnt_q == 8'd1) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                out_valid = 1'b1;
                out_data  = chk_q;
                if (hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Pop must also be reflected in the overflow decision above.
        overflow_d = overflow_d & ~(fifo_pop & ~overflow_q & ~(wren_fifo_tx && fifo_full && !fifo_pop));
    end

    // Framer registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pre_cnt_q  <= 4'd0;
            pay_cnt_q  <= 8'd0;
            type_q     <= 8'h00;
            len_q      <= 8'h00;
            chk_q      <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            type_q     <= type_d;
            len_q      <= len_d;
            chk_q      <= chk_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
